// File: rtl/count_binner_pkg.sv
// count_binner_pkg
// Shared types and constants for the photon-count time binner.
//   state_t      : binning FSM states (IDLE, RUN)
//   entry_t      : one FIFO entry {seq, phase, delta} at the default widths
//   ENTRY_W      : packed width of entry_t
//   DROPW        : width of the saturating dropped-bin counter
//   entry_width(): entry width for any COUNTSIZE/SEQW combination
package count_binner_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_COUNTSIZE = 32;
    localparam int DEF_SEQW      = 8;
    localparam int DROPW         = 16;

    // Field order matters: the sequence number sits in the top bits so a
    // packed entry reads naturally as {seq, phase, delta}.
    typedef struct packed {
        logic [DEF_SEQW-1:0]      seq;
        logic                     phase;
        logic [DEF_COUNTSIZE-1:0] delta;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic int entry_width(input int countsize, input int seqw);
        return seqw + 1 + countsize;
    endfunction

endpackage

// File: rtl/count_binner_if.sv
// count_binner_if
// Valid/ready output stream carrying one bin result per beat.
//   m_data  : bin delta (COUNTSIZE bits)
//   m_phase : lock-in phase captured at the snapshot edge
//   m_seq   : bin sequence number (SEQW bits)
//   m_valid : head entry present
//   m_ready : consumer accepts the head entry this cycle
// Modports: master (binner side), slave (host readout side).
interface count_binner_if
    import count_binner_pkg::*;
#(
    parameter int COUNTSIZE = DEF_COUNTSIZE,
    parameter int SEQW      = DEF_SEQW
) ();

    logic [COUNTSIZE-1:0] m_data;
    logic                 m_phase;
    logic [SEQW-1:0]      m_seq;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        output m_data,
        output m_phase,
        output m_seq,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_phase,
        input  m_seq,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/count_binner_sync_fifo.sv
// sync_fifo
// Single-clock show-ahead FIFO used to buffer bin results.
//   clk, rst : clock and synchronous active-high reset
//   wr_en    : write request; accepted when not full, or when full with a
//              read on the same edge
//   wr_data  : entry to write
//   rd_en    : pop the head entry (ignored while empty)
//   rd_data  : head entry, zero while empty
//   full     : DEPTH entries held
//   empty    : no entries held
//   fill     : current occupancy, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign fill  = count;

    // When full, the slot being written is the one being read out on the
    // same edge, so a simultaneous read frees room for the write.
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    // Pointers wrap naturally because DEPTH is a power of two; occupancy is
    // tracked separately so full and empty are never ambiguous.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; stale contents are hidden by the empty gate.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/count_binner.sv
// count_binner
// Cuts the running photon count into fixed-length bins and streams the
// per-bin delta, tagged with lock-in phase and a sequence number, through
// a small show-ahead FIFO.
//   c_clk, c_rst   : clock and synchronous active-high reset
//   c_enable       : binning runs while high; dropping it discards the
//                    partial bin
//   c_clear        : pulse clearing c_overflow and c_drop_cnt
//   c_bin_period   : bin length in cycles (0 behaves as 1)
//   c_cnt          : running count from photon_counter
//   c_lockin_inc   : lock-in phase from photon_counter
//   m              : output stream (master modport)
//   c_fill         : FIFO occupancy
//   c_overflow     : sticky, set whenever a bin is dropped on a full FIFO
//   c_drop_cnt     : saturating count of dropped bins
module count_binner
    import count_binner_pkg::*;
#(
    parameter int COUNTSIZE = DEF_COUNTSIZE,
    parameter int DEPTH     = 16,
    parameter int SEQW      = DEF_SEQW
) (
    input  logic                   c_clk,
    input  logic                   c_rst,
    input  logic                   c_enable,
    input  logic                   c_clear,
    input  logic [COUNTSIZE-1:0]   c_bin_period,
    input  logic [COUNTSIZE-1:0]   c_cnt,
    input  logic                   c_lockin_inc,
    count_binner_if.master         m,
    output logic [$clog2(DEPTH):0] c_fill,
    output logic                   c_overflow,
    output logic [DROPW-1:0]       c_drop_cnt
);

    localparam int EW = entry_width(COUNTSIZE, SEQW);

    typedef struct packed {
        logic [SEQW-1:0]      seq;
        logic                 phase;
        logic [COUNTSIZE-1:0] delta;
    } bin_entry_t;

    state_t               state;
    state_t               state_next;
    logic [COUNTSIZE-1:0] timer;
    logic [COUNTSIZE-1:0] baseline;
    logic [COUNTSIZE-1:0] period;
    logic [SEQW-1:0]      seq;
    logic                 capture;
    logic                 snap;
    logic                 advance;
    logic                 pop;
    logic                 drop;
    logic                 full;
    logic                 empty;
    bin_entry_t           push_entry;
    bin_entry_t           head_entry;
    logic [EW-1:0]        head_bits;

    assign period = (c_bin_period == '0) ? COUNTSIZE'(1) : c_bin_period;

    // Next-state and per-cycle actions. The >= compare closes a bin right
    // away if the period is shortened below the elapsed time.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        snap       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (c_enable) begin
                    capture    = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!c_enable) begin
                    state_next = IDLE;
                end else if (timer >= period) begin
                    snap = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus bin bookkeeping. The sequence number advances on
    // every snapshot, including dropped ones, so the host can see gaps.
    always_ff @(posedge c_clk) begin
        if (c_rst) begin
            state    <= IDLE;
            timer    <= '0;
            baseline <= '0;
            seq      <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                baseline <= c_cnt;
                timer    <= COUNTSIZE'(1);
            end else if (snap) begin
                baseline <= c_cnt;
                timer    <= COUNTSIZE'(1);
                seq      <= seq + 1'b1;
            end else if (advance) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Modulo subtraction: a falling count yields a two's-complement delta.
    always_comb begin
        push_entry       = '0;
        push_entry.seq   = seq;
        push_entry.phase = c_lockin_inc;
        push_entry.delta = c_cnt - baseline;
    end

    assign pop  = m.m_valid && m.m_ready;
    assign drop = snap && full && !pop;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) fifo (
        .clk     (c_clk),
        .rst     (c_rst),
        .wr_en   (snap),
        .wr_data (push_entry),
        .rd_en   (pop),
        .rd_data (head_bits),
        .full    (full),
        .empty   (empty),
        .fill    (c_fill)
    );

    assign head_entry = bin_entry_t'(head_bits);
    assign m.m_valid  = !empty;
    assign m.m_data   = head_entry.delta;
    assign m.m_phase  = head_entry.phase;
    assign m.m_seq    = head_entry.seq;

    // Drop accounting. A drop on the same edge as c_clear wins, leaving the
    // flag set and the counter at one.
    always_ff @(posedge c_clk) begin
        if (c_rst) begin
            c_overflow <= 1'b0;
            c_drop_cnt <= '0;
        end else if (drop) begin
            c_overflow <= 1'b1;
            if (c_clear) begin
                c_drop_cnt <= DROPW'(1);
            end else if (c_drop_cnt != '1) begin
                c_drop_cnt <= c_drop_cnt + 1'b1;
            end
        end else if (c_clear) begin
            c_overflow <= 1'b0;
            c_drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_count_binner.sv
// tb_count_binner
// Directed bench for count_binner. Expected beats go into a scoreboard queue
// as each scenario is driven; a negedge monitor pops and compares every beat
// the DUT hands over.
module tb_count_binner;
    import count_binner_pkg::*;

    localparam int CS    = 32;
    localparam int DEPTH = 16;
    localparam int SEQW  = 8;

    logic        c_clk = 1'b0;
    logic        c_rst;
    logic        c_enable;
    logic        c_clear;
    logic [31:0] c_bin_period;
    logic [31:0] c_cnt;
    logic        c_lockin_inc;
    logic [4:0]  c_fill;
    logic        c_overflow;
    logic [15:0] c_drop_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [40:0] sb [$];
    logic [7:0]  exp_seq;
    logic [40:0] mon_exp;

    count_binner_if #(.COUNTSIZE(CS), .SEQW(SEQW)) bus ();

    count_binner #(
        .COUNTSIZE (CS),
        .DEPTH     (DEPTH),
        .SEQW      (SEQW)
    ) dut (
        .c_clk        (c_clk),
        .c_rst        (c_rst),
        .c_enable     (c_enable),
        .c_clear      (c_clear),
        .c_bin_period (c_bin_period),
        .c_cnt        (c_cnt),
        .c_lockin_inc (c_lockin_inc),
        .m            (bus),
        .c_fill       (c_fill),
        .c_overflow   (c_overflow),
        .c_drop_cnt   (c_drop_cnt)
    );

    always #5 c_clk = ~c_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Runs whole cycles; c_cnt moves by step after every 'every'-th edge.
    task automatic applyStimulus(input int cycles, input logic [31:0] step, input int every);
        for (int j = 0; j < cycles; j++) begin
            @(posedge c_clk);
            #1;
            if (j % every == 0) c_cnt = c_cnt + step;
        end
    endtask

    task automatic expectBeat(input logic phase, input logic [31:0] data);
        sb.push_back({exp_seq, phase, data});
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge c_clk);
            #1;
            n++;
        end
        checkOutput("drain_complete", 64'(sb.size()), 64'd0);
        sb.delete();
        @(posedge c_clk);
        #1;
        checkOutput("idle_after_drain", 64'(bus.m_valid), 64'd0);
    endtask

    task automatic doReset();
        c_rst = 1'b1;
        applyStimulus(2, 32'd0, 1);
        c_rst = 1'b0;
        sb.delete();
        exp_seq = 8'd0;
    endtask

    // Beat monitor: a handshake seen here completes on the next posedge.
    always @(negedge c_clk) begin
        if (!c_rst && bus.m_valid && bus.m_ready) begin
            checkOutput("beat_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                checkOutput("beat", {23'd0, bus.m_seq, bus.m_phase, bus.m_data}, {23'd0, mon_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        c_rst        = 1'b1;
        c_enable     = 1'b0;
        c_clear      = 1'b0;
        c_bin_period = 32'd4;
        c_cnt        = 32'd0;
        c_lockin_inc = 1'b0;
        bus.m_ready  = 1'b0;
        exp_seq      = 8'd0;

        // Reset state
        applyStimulus(2, 32'd0, 1);
        checkOutput("rst_valid", 64'(bus.m_valid), 64'd0);
        checkOutput("rst_fill", 64'(c_fill), 64'd0);
        checkOutput("rst_overflow", 64'(c_overflow), 64'd0);
        checkOutput("rst_drop_cnt", 64'(c_drop_cnt), 64'd0);
        checkOutput("rst_data", 64'(bus.m_data), 64'd0);
        checkOutput("rst_seq", 64'(bus.m_seq), 64'd0);
        c_rst = 1'b0;

        // Basic binning: P=4, +1 per cycle, 13 enabled edges -> 3 beats of 4
        $display("[TB] basic binning");
        c_bin_period = 32'd4;
        c_lockin_inc = 1'b1;
        bus.m_ready  = 1'b1;
        repeat (3) expectBeat(1'b1, 32'd4);
        c_enable = 1'b1;
        applyStimulus(13, 32'd1, 1);
        c_enable = 1'b0;
        waitDrain(20);

        // Negative delta: -2 per bin at P=5, phase 0
        $display("[TB] negative delta");
        c_bin_period = 32'd5;
        c_lockin_inc = 1'b0;
        repeat (2) expectBeat(1'b0, 32'hFFFF_FFFE);
        c_enable = 1'b1;
        applyStimulus(11, 32'hFFFF_FFFE, 5);
        c_enable = 1'b0;
        waitDrain(20);

        // Wrap: count crosses 0xFFFFFFFF -> 0x00000002 inside one bin
        $display("[TB] counter wrap");
        c_cnt        = 32'hFFFF_FFFF;
        c_bin_period = 32'd1;
        c_lockin_inc = 1'b1;
        expectBeat(1'b1, 32'd3);
        c_enable = 1'b1;
        applyStimulus(2, 32'd3, 1);
        c_enable = 1'b0;
        waitDrain(20);

        // Overflow: 20 bins into a stalled 16-deep FIFO
        $display("[TB] overflow");
        doReset();
        c_bin_period = 32'd2;
        bus.m_ready  = 1'b0;
        repeat (16) expectBeat(1'b1, 32'd2);
        exp_seq  = exp_seq + 8'd4;
        c_enable = 1'b1;
        applyStimulus(41, 32'd1, 1);
        c_enable = 1'b0;
        applyStimulus(1, 32'd0, 1);
        checkOutput("ovf_fill", 64'(c_fill), 64'd16);
        checkOutput("ovf_drop_cnt", 64'(c_drop_cnt), 64'd4);
        checkOutput("ovf_flag", 64'(c_overflow), 64'd1);
        checkOutput("ovf_head_seq", 64'(bus.m_seq), 64'd0);
        bus.m_ready = 1'b1;
        waitDrain(40);
        expectBeat(1'b1, 32'd2);
        c_enable = 1'b1;
        applyStimulus(3, 32'd1, 1);
        c_enable = 1'b0;
        waitDrain(20);
        checkOutput("ovf_sticky", 64'(c_overflow), 64'd1);
        c_clear = 1'b1;
        applyStimulus(1, 32'd0, 1);
        c_clear = 1'b0;
        checkOutput("clear_flag", 64'(c_overflow), 64'd0);
        checkOutput("clear_drop_cnt", 64'(c_drop_cnt), 64'd0);

        // Disable mid-bin at timer=5, idle jumps in c_cnt, then re-enable
        $display("[TB] disable mid-bin");
        c_bin_period = 32'd10;
        c_lockin_inc = 1'b0;
        bus.m_ready  = 1'b0;
        c_enable     = 1'b1;
        applyStimulus(5, 32'd1, 1);
        c_enable = 1'b0;
        applyStimulus(3, 32'd100, 1);
        checkOutput("dis_fill", 64'(c_fill), 64'd0);
        checkOutput("dis_valid", 64'(bus.m_valid), 64'd0);
        bus.m_ready = 1'b1;
        expectBeat(1'b0, 32'd10);
        c_enable = 1'b1;
        applyStimulus(11, 32'd1, 1);
        c_enable = 1'b0;
        waitDrain(20);

        // Reset mid-run with a full FIFO and overflow set
        $display("[TB] reset mid-run");
        c_bin_period = 32'd1;
        bus.m_ready  = 1'b0;
        c_enable     = 1'b1;
        applyStimulus(18, 32'd1, 1);
        checkOutput("pre_rst_fill", 64'(c_fill), 64'd16);
        checkOutput("pre_rst_overflow", 64'(c_overflow), 64'd1);
        c_rst = 1'b1;
        applyStimulus(1, 32'd1, 1);
        checkOutput("mrst_valid", 64'(bus.m_valid), 64'd0);
        checkOutput("mrst_fill", 64'(c_fill), 64'd0);
        checkOutput("mrst_overflow", 64'(c_overflow), 64'd0);
        checkOutput("mrst_drop_cnt", 64'(c_drop_cnt), 64'd0);
        checkOutput("mrst_data", 64'(bus.m_data), 64'd0);
        c_rst = 1'b0;
        sb.delete();
        exp_seq     = 8'd0;
        bus.m_ready = 1'b1;
        expectBeat(1'b0, 32'd1);
        applyStimulus(2, 32'd1, 1);
        c_enable = 1'b0;
        waitDrain(20);

        // Period 0: one bin per cycle, delta equals the per-cycle step
        $display("[TB] period zero");
        c_bin_period = 32'd0;
        c_lockin_inc = 1'b1;
        repeat (5) expectBeat(1'b1, 32'd7);
        c_enable = 1'b1;
        applyStimulus(6, 32'd7, 1);
        c_enable = 1'b0;
        waitDrain(20);

        // Full FIFO with push and pop on the same edge: no drop
        $display("[TB] full fifo push+pop");
        bus.m_ready = 1'b0;
        repeat (17) expectBeat(1'b1, 32'd1);
        c_enable = 1'b1;
        applyStimulus(17, 32'd1, 1);
        checkOutput("full_fill", 64'(c_fill), 64'd16);
        bus.m_ready = 1'b1;
        applyStimulus(1, 32'd1, 1);
        c_enable    = 1'b0;
        bus.m_ready = 1'b0;
        checkOutput("pushpop_fill", 64'(c_fill), 64'd16);
        checkOutput("pushpop_drop_cnt", 64'(c_drop_cnt), 64'd0);
        checkOutput("pushpop_overflow", 64'(c_overflow), 64'd0);
        bus.m_ready = 1'b1;
        waitDrain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
